moldudp64_encoder: RTL and testbench
====================================

// Module: moldudp64_encoder
// PURPOSE
// - Transmit-side MoldUDP64 framer. Serialises a packet header (session, sequence number, message count)
//   and then per-message [2-byte length | data] onto a byte-wide UDP payload stream.
// - Sits between the market-data message source and the UDP TX payload path.
// - Mirror of the MoldUDP64 RX decoder. All multi-byte fields are sent big-endian, MSB first.
// PARAMETERS
// - MSG_LEN_MAX  16'd1450  message lengths above this raise len_err (the message is still sent as given)
// PORTS
// - clk                 in   1   single clock domain
// - rst                 in   1   synchronous reset, active-high
// - hdr_valid           in   1   packet request handshake
// - hdr_ready           out  1   high only in IDLE
// - hdr_session         in   80  session ID, sampled on hdr handshake
// - hdr_seq_num         in   64  sequence number of the first message
// - hdr_msg_cnt         in   16  message count; 16'h0000 = heartbeat, 16'hFFFF = end of session
// - len_valid/len_ready in/out 1 per-message length handshake
// - len_data            in   16  message length in bytes (0 allowed)
// - msg_valid/msg_ready in/out 1 message byte handshake
// - msg_data            in   8   message byte
// - msg_last            in   1   last byte of message; checked only, never used for framing
// - udp_payload_data    out  8   payload byte
// - udp_payload_valid   out  1
// - udp_payload_ready   in   1   downstream backpressure
// - udp_payload_last    out  1   last byte of the UDP payload
// - seq_num_next        out  64  registered hdr_seq_num + msg_cnt (or + 0 for 0000/FFFF), for the next packet
// - len_err             out  1   1-cycle pulse: len_data > MSG_LEN_MAX
// - last_err            out  1   1-cycle pulse: msg_last disagrees with the length-derived last byte
// BEHAVIOUR
// - Reset values:
//   - All outputs 0, state IDLE, byte counter 0.
//   - hdr_ready is 1 the cycle after rst drops.
// - rst asserted mid-packet: the packet is abandoned with no udp_payload_last and no flush. Next packet starts clean.
// - A byte transfers when valid & ready. udp_payload_data/valid/last hold stable while valid & !ready.
// - States:
//   - IDLE: hdr_ready=1. On handshake, latch the fields and zero byte_cnt. Next state HDR.
//     The first payload byte is valid on the next cycle.
//   - HDR: emits 20 bytes, byte_cnt 0..19: session[79:0], then seq[63:0], then cnt[15:0].
//     After byte 19: if cnt is 0000 or FFFF, assert last on byte 19 and go to IDLE; otherwise go to LEN_WAIT.
//   - LEN_WAIT: len_ready=1, udp_payload_valid=0. On handshake, latch the length (check len_err). Go to LEN.
//   - LEN: emits len[15:8], then len[7:0]. If len==0, skip DATA.
//   - DATA: pass-through; udp_payload_valid=msg_valid, msg_ready=udp_payload_ready.
//     The remaining-byte counter decrements on each transfer.
//     last_err pulses on a transfer where msg_last != (remaining==1).
//   - End of each message: decrement the messages-left counter.
//     If it reaches 0, assert udp_payload_last on this final byte (the final data byte, or the 2nd length byte
//     when len==0) and go to IDLE. Otherwise go to LEN_WAIT.
// - Ready outputs:
//   - msg_ready=0 outside DATA.
//   - len_ready=0 outside LEN_WAIT.
//   - hdr_ready=0 outside IDLE.
// - The only combinational ready/valid paths are the DATA pass-through. All header/length bytes come from registers.
// - Arithmetic: byte_cnt is 5 bits; remaining-bytes and msgs-left counters are 16 bits unsigned.
//   - seq_num_next is computed as 64-bit + zero-extended cnt and wraps mod 2^64.
//   - It is updated on the hdr handshake.
// - Back-to-back packets: hdr_ready rises the cycle after the last transfer. There are no idle payload gaps inside a packet other than stalls.
// STRUCTURE
// - moldudp64_pkg holds the shared RX/TX definitions:
//   - SESSION_LEN=10, SEQ_NUM_LEN=8, MSG_CNT_LEN=2, HDR_LEN=20
//   - MSG_CNT_HEARTBEAT=16'h0000, MSG_CNT_END_SESSION=16'hFFFF
//   - the TX state enum.
// - Single flat module, two-process FSM (always_ff + always_comb). No sub-module is warranted.
// TESTING
// - Heartbeat: session 'h0102..0A, seq 5, cnt 0.
//   -> 20 bytes out, last on byte 19, seq_num_next=5, no len handshake.
// - Two messages: cnt=2, lens 3 ('AA BB CC') and 1 ('DD').
//   -> header, then 00 03 AA BB CC 00 01 DD, last on DD, seq_num_next=seq+2.
// - Zero-length message: cnt=1, len=0.
//   -> header, then 00 00 with last on the second 00. msg_ready never asserted.
// - Backpressure: toggle udp_payload_ready randomly 50%.
//   -> byte sequence identical to the unstalled run; data held stable while stalled.
// - Errors: len=1500 -> len_err pulse; msg_last on byte 2 of 3 -> last_err pulse. Framing unchanged in both cases.
// - Reset in DATA after 2 of 5 bytes -> all outputs 0, hdr_ready=1 the next cycle, next packet correct.

Source files
------------

// File: rtl/moldudp64_pkg.sv
// Definitions shared by the MoldUDP64 RX decoder and TX encoder: field sizes,
// special message counts and the TX framer state encoding.
package moldudp64_pkg;

  localparam int SESSION_LEN = 10;
  localparam int SEQ_NUM_LEN = 8;
  localparam int MSG_CNT_LEN = 2;
  localparam int HDR_LEN     = 20;

  localparam logic [15:0] MSG_CNT_HEARTBEAT   = 16'h0000;
  localparam logic [15:0] MSG_CNT_END_SESSION = 16'hFFFF;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HDR,
    TX_LEN_WAIT,
    TX_LEN,
    TX_DATA
  } tx_state_e;

  // Heartbeat and end-of-session packets are header-only.
  function automatic logic is_no_msg(input logic [15:0] cnt);
    return (cnt == MSG_CNT_HEARTBEAT) || (cnt == MSG_CNT_END_SESSION);
  endfunction

endpackage

// File: rtl/moldudp64_encoder.sv
// Transmit-side MoldUDP64 framer: header, then per-message [length | data],
// serialised big-endian onto a byte-wide UDP payload stream.
module moldudp64_encoder
  import moldudp64_pkg::*;
#(
  parameter logic [15:0] MSG_LEN_MAX = 16'd1450
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hdr_valid,
  output logic                       hdr_ready,
  input  logic [8*SESSION_LEN-1:0]   hdr_session,
  input  logic [8*SEQ_NUM_LEN-1:0]   hdr_seq_num,
  input  logic [8*MSG_CNT_LEN-1:0]   hdr_msg_cnt,
  input  logic                       len_valid,
  output logic                       len_ready,
  input  logic [15:0]                len_data,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [7:0]                 msg_data,
  input  logic                       msg_last,
  output logic [7:0]                 udp_payload_data,
  output logic                       udp_payload_valid,
  input  logic                       udp_payload_ready,
  output logic                       udp_payload_last,
  output logic [8*SEQ_NUM_LEN-1:0]   seq_num_next,
  output logic                       len_err,
  output logic                       last_err
);

  tx_state_e                state, state_next;
  logic [4:0]               byte_cnt;
  logic [8*SESSION_LEN-1:0] session_q;
  logic [8*SEQ_NUM_LEN-1:0] seq_q;
  logic [15:0]              cnt_q;
  logic [15:0]              len_q;
  logic [15:0]              rem_q;
  logic [15:0]              msgs_left_q;
  logic                     hdr_ready_q;
  logic                     hdr_fire;
  logic                     msg_end;

  assign hdr_ready = hdr_ready_q;
  assign hdr_fire  = hdr_valid & hdr_ready_q;

  function automatic logic [7:0] hdr_byte(input logic [8*HDR_LEN-1:0] hdr,
                                          input logic [4:0] idx);
    logic [8*HDR_LEN-1:0] sh;
    sh = hdr << {idx, 3'b000};
    return sh[8*HDR_LEN-1 -: 8];
  endfunction

  always_comb begin
    state_next        = state;
    len_ready         = 1'b0;
    msg_ready         = 1'b0;
    udp_payload_valid = 1'b0;
    udp_payload_data  = 8'h00;
    udp_payload_last  = 1'b0;
    msg_end           = 1'b0;
    case (state)
      TX_IDLE: begin
        if (hdr_fire) state_next = TX_HDR;
      end
      TX_HDR: begin
        udp_payload_valid = 1'b1;
        udp_payload_data  = hdr_byte({session_q, seq_q, cnt_q}, byte_cnt);
        udp_payload_last  = (byte_cnt == 5'(HDR_LEN-1)) && is_no_msg(cnt_q);
        if (udp_payload_ready && byte_cnt == 5'(HDR_LEN-1))
          state_next = is_no_msg(cnt_q) ? TX_IDLE : TX_LEN_WAIT;
      end
      TX_LEN_WAIT: begin
        len_ready = 1'b1;
        if (len_valid) state_next = TX_LEN;
      end
      TX_LEN: begin
        udp_payload_valid = 1'b1;
        udp_payload_data  = byte_cnt[0] ? len_q[7:0] : len_q[15:8];
        msg_end           = byte_cnt[0] && (len_q == 16'd0);
        udp_payload_last  = msg_end && (msgs_left_q == 16'd1);
        if (udp_payload_ready && byte_cnt[0]) begin
          if (len_q != 16'd0)             state_next = TX_DATA;
          else if (msgs_left_q == 16'd1)  state_next = TX_IDLE;
          else                            state_next = TX_LEN_WAIT;
        end
      end
      TX_DATA: begin
        // Only combinational ready/valid path: straight pass-through of the message stream.
        udp_payload_valid = msg_valid;
        msg_ready         = udp_payload_ready;
        udp_payload_data  = msg_data;
        msg_end           = (rem_q == 16'd1);
        udp_payload_last  = msg_end && (msgs_left_q == 16'd1);
        if (msg_valid && udp_payload_ready && msg_end)
          state_next = (msgs_left_q == 16'd1) ? TX_IDLE : TX_LEN_WAIT;
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // Control: state, counters, ready and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= TX_IDLE;
      byte_cnt     <= 5'd0;
      hdr_ready_q  <= 1'b0;
      rem_q        <= 16'd0;
      msgs_left_q  <= 16'd0;
      seq_num_next <= '0;
      len_err      <= 1'b0;
      last_err     <= 1'b0;
    end else begin
      state       <= state_next;
      hdr_ready_q <= (state_next == TX_IDLE);
      len_err     <= 1'b0;
      last_err    <= 1'b0;
      case (state)
        TX_IDLE: if (hdr_fire) begin
          byte_cnt     <= 5'd0;
          msgs_left_q  <= hdr_msg_cnt;
          seq_num_next <= hdr_seq_num +
                          (is_no_msg(hdr_msg_cnt) ? 64'd0 : {48'd0, hdr_msg_cnt});
        end
        TX_HDR: if (udp_payload_ready)
          byte_cnt <= (byte_cnt == 5'(HDR_LEN-1)) ? 5'd0 : byte_cnt + 5'd1;
        TX_LEN_WAIT: if (len_valid) begin
          rem_q    <= len_data;
          len_err  <= (len_data > MSG_LEN_MAX);
          byte_cnt <= 5'd0;
        end
        TX_LEN: if (udp_payload_ready) begin
          byte_cnt <= byte_cnt + 5'd1;
          if (msg_end) msgs_left_q <= msgs_left_q - 16'd1;
        end
        TX_DATA: if (msg_valid && udp_payload_ready) begin
          rem_q    <= rem_q - 16'd1;
          last_err <= (msg_last != msg_end);
          if (msg_end) msgs_left_q <= msgs_left_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Data: header fields and message length, captured on their handshakes
  always_ff @(posedge clk) begin
    if (state == TX_IDLE && hdr_fire) begin
      session_q <= hdr_session;
      seq_q     <= hdr_seq_num;
      cnt_q     <= hdr_msg_cnt;
    end
    if (state == TX_LEN_WAIT && len_valid) len_q <= len_data;
  end

endmodule

// File: tb/tb_moldudp64_encoder.sv
// Directed bench for the MoldUDP64 TX framer: table of packet vectors plus
// hand-written reset and byte-literal sequences.
module tb_moldudp64_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        hdr_valid, hdr_ready;
  logic [79:0] hdr_session;
  logic [63:0] hdr_seq_num;
  logic [15:0] hdr_msg_cnt;
  logic        len_valid, len_ready;
  logic [15:0] len_data;
  logic        msg_valid, msg_ready;
  logic [7:0]  msg_data;
  logic        msg_last;
  logic [7:0]  udp_payload_data;
  logic        udp_payload_valid, udp_payload_ready, udp_payload_last;
  logic [63:0] seq_num_next;
  logic        len_err, last_err;

  always #5 clk = ~clk;

  moldudp64_encoder dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_session(hdr_session),
    .hdr_seq_num(hdr_seq_num), .hdr_msg_cnt(hdr_msg_cnt),
    .len_valid(len_valid), .len_ready(len_ready), .len_data(len_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .udp_payload_data(udp_payload_data), .udp_payload_valid(udp_payload_valid),
    .udp_payload_ready(udp_payload_ready), .udp_payload_last(udp_payload_last),
    .seq_num_next(seq_num_next), .len_err(len_err), .last_err(last_err)
  );

  typedef struct {
    logic [79:0] session;
    logic [63:0] seq;
    logic [15:0] cnt;
    logic [15:0] len0;
    logic [15:0] len1;
    int          early_last;
    bit          stall;
    logic [63:0] exp_next;
    int          exp_len_err;
    int          exp_last_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];
  logic [7:0] cap[$];
  logic [7:0] expq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hdr_valid = 1'b0; len_valid = 1'b0; len_data = 16'h0;
    msg_valid = 1'b0; msg_data = 8'h0; msg_last = 1'b0; udp_payload_ready = 1'b1;
  endtask

  task automatic run_pkt(input vec_t v, input int abort_after);
    logic [15:0] lq[$];
    logic [7:0]  mqd[$];
    bit          mql[$];
    int nmsg, gidx, cycles, msg_xfers, len_xfers, last_cnt, last_idx;
    int lerr, laerr, hold_err, mism, first_bad;
    bit hdr_pend, done, mr_seen, prev_stall, prev_last;
    logic [7:0] prev_data;
    logic [15:0] ln;

    cap.delete(); expq.delete();
    nmsg = (v.cnt == 16'h0000 || v.cnt == 16'hFFFF) ? 0 : int'(v.cnt);
    for (int k = 0; k < 10; k++) expq.push_back(v.session[79-8*k -: 8]);
    for (int k = 0; k < 8; k++)  expq.push_back(v.seq[63-8*k -: 8]);
    expq.push_back(v.cnt[15:8]); expq.push_back(v.cnt[7:0]);
    gidx = 0;
    for (int m = 0; m < nmsg; m++) begin
      ln = (m == 0) ? v.len0 : v.len1;
      lq.push_back(ln);
      expq.push_back(ln[15:8]); expq.push_back(ln[7:0]);
      for (int b = 0; b < int'(ln); b++) begin
        mqd.push_back(8'((170 + 17*gidx) & 255));
        mql.push_back((b == int'(ln) - 1) || (m == 0 && b == v.early_last));
        expq.push_back(8'((170 + 17*gidx) & 255));
        gidx++;
      end
    end

    hdr_pend = 1'b1; done = 1'b0; mr_seen = 1'b0; prev_stall = 1'b0;
    prev_data = 8'h0; prev_last = 1'b0;
    cycles = 0; msg_xfers = 0; len_xfers = 0; last_cnt = 0; last_idx = -1;
    lerr = 0; laerr = 0; hold_err = 0;
    hdr_session = v.session; hdr_seq_num = v.seq; hdr_msg_cnt = v.cnt;

    while (!done) begin
      @(negedge clk);
      hdr_valid = hdr_pend;
      len_valid = (lq.size() > 0);
      len_data  = (lq.size() > 0) ? lq[0] : 16'h0;
      msg_valid = (mqd.size() > 0);
      msg_data  = (mqd.size() > 0) ? mqd[0] : 8'h0;
      msg_last  = (mql.size() > 0) ? mql[0] : 1'b0;
      udp_payload_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_stall && !(udp_payload_valid && udp_payload_data == prev_data &&
                          udp_payload_last == prev_last)) hold_err++;
      prev_stall = udp_payload_valid && !udp_payload_ready;
      prev_data  = udp_payload_data;
      prev_last  = udp_payload_last;
      if (hdr_valid && hdr_ready) hdr_pend = 1'b0;
      if (len_valid && len_ready) begin void'(lq.pop_front()); len_xfers++; end
      if (msg_ready) mr_seen = 1'b1;
      if (msg_valid && msg_ready) begin
        void'(mqd.pop_front()); void'(mql.pop_front()); msg_xfers++;
      end
      if (len_err) lerr++;
      if (last_err) laerr++;
      if (udp_payload_valid && udp_payload_ready) begin
        cap.push_back(udp_payload_data);
        if (udp_payload_last) begin
          last_cnt++; last_idx = cap.size() - 1; done = 1'b1;
        end
      end
      if (abort_after >= 0 && msg_xfers == abort_after) break;
      cycles++;
      if (cycles > 8000) begin
        check("packet_timeout", 64'(cycles), 64'd8000);
        break;
      end
    end

    if (abort_after >= 0) begin
      check("abort_no_last", 64'(last_cnt), 64'd0);
      check("abort_data_xfers", 64'(msg_xfers), 64'(abort_after));
      return;
    end

    @(negedge clk);
    idle_inputs();
    #1;
    if (len_err) lerr++;
    if (last_err) laerr++;
    check("hdr_ready_after_last", 64'(hdr_ready), 64'd1);

    mism = 0; first_bad = -1;
    for (int k = 0; k < expq.size() && k < cap.size(); k++)
      if (cap[k] !== expq[k]) begin
        mism++;
        if (first_bad < 0) first_bad = k;
      end
    if (first_bad >= 0)
      $display("first differing byte %0d: got %0h expected %0h", first_bad,
               cap[first_bad], expq[first_bad]);
    check("byte_count", 64'(cap.size()), 64'(expq.size()));
    check("byte_mismatches", 64'(mism), 64'd0);
    check("last_count", 64'(last_cnt), 64'd1);
    check("last_position", 64'(last_idx), 64'(expq.size() - 1));
    check("seq_num_next", seq_num_next, v.exp_next);
    check("len_xfers", 64'(len_xfers), 64'(nmsg));
    check("len_err_pulses", 64'(lerr), 64'(v.exp_len_err));
    check("last_err_pulses", 64'(laerr), 64'(v.exp_last_err));
    check("msg_ready_seen", 64'(mr_seen), 64'(gidx > 0));
    check("stall_hold", 64'(hold_err), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_hdr_ready"}, 64'(hdr_ready), 64'd0);
    check({tag, "_len_ready"}, 64'(len_ready), 64'd0);
    check({tag, "_msg_ready"}, 64'(msg_ready), 64'd0);
    check({tag, "_valid"}, 64'(udp_payload_valid), 64'd0);
    check({tag, "_data"}, 64'(udp_payload_data), 64'd0);
    check({tag, "_last"}, 64'(udp_payload_last), 64'd0);
    check({tag, "_len_err"}, 64'(len_err), 64'd0);
    check({tag, "_last_err"}, 64'(last_err), 64'd0);
  endtask

  initial begin
    logic [7:0] two_msg[8];
    vec_t ab;
    two_msg = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h01, 8'hDD};
    hdr_session = '0; hdr_seq_num = '0; hdr_msg_cnt = '0;
    idle_inputs();

    //            session                      seq                    cnt     len0    len1   early stall exp_next               lerr laerr
    vecs[0] = '{80'h0102030405060708090A, 64'd5,                  16'd0,  16'd0,    16'd0, -1, 1'b0, 64'd5,                  0, 0};
    vecs[1] = '{80'h11121314151617181920, 64'd100,                16'd2,  16'd3,    16'd1, -1, 1'b0, 64'd102,                0, 0};
    vecs[2] = '{80'hA0A1A2A3A4A5A6A7A8A9, 64'd7,                  16'd1,  16'd0,    16'd0, -1, 1'b0, 64'd8,                  0, 0};
    vecs[3] = '{80'h11121314151617181920, 64'd200,                16'd2,  16'd3,    16'd1, -1, 1'b1, 64'd202,                0, 0};
    vecs[4] = '{80'h0,                    64'd0,                  16'd1,  16'd1500, 16'd0, -1, 1'b0, 64'd1,                  1, 0};
    vecs[5] = '{80'hFFEEDDCCBBAA99887766, 64'd40,                 16'd1,  16'd3,    16'd0,  1, 1'b0, 64'd41,                 0, 1};
    vecs[6] = '{80'h5,                    64'hFFFF_FFFF_FFFF_FFF0, 16'hFFFF, 16'd0, 16'd0, -1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0};
    vecs[7] = '{80'h6,                    64'hFFFF_FFFF_FFFF_FFFF, 16'd1,  16'd1,    16'd0, -1, 1'b0, 64'd0,                  0, 0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check("reset_seq_num_next", seq_num_next, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("hdr_ready_after_reset", 64'(hdr_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      run_pkt(vecs[i], -1);
      if (i == 0) begin
        check("hb_byte0", 64'(cap[0]), 64'h01);
        check("hb_byte9", 64'(cap[9]), 64'h0A);
        check("hb_byte17", 64'(cap[17]), 64'h05);
      end
      if (i == 1)
        for (int k = 0; k < 8; k++)
          check($sformatf("two_msg_byte%0d", 20 + k), 64'(cap[20+k]), 64'(two_msg[k]));
    end

    ab = '{80'h77, 64'd9, 16'd1, 16'd5, 16'd0, -1, 1'b0, 64'd10, 0, 0};
    run_pkt(ab, 2);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("hdr_ready_after_midrst", 64'(hdr_ready), 64'd1);
    run_pkt(vecs[1], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
